key_debounce16: RTL

Sixteen-channel input conditioner that sits directly upstream of the 16-to-4 priority encoder. It synchronises raw switch/button lines to `clk`, debounces each line against a shared sample tick, and presents a clean 16-bit level vector. It also produces single-cycle press pulses and a sticky press register. The encoder consumes `keys` (level) or `held` (sticky) unchanged; both are plain 16-bit vectors, bit i = channel i.

---
 rtl/key_debounce16_pkg.sv | 8 +
 rtl/key_debounce16_if.sv | 21 ++
 rtl/key_debounce16_debounce_bit.sv | 52 +++++
 rtl/key_debounce16.sv | 62 ++++++
 4 files changed

// File: rtl/key_debounce16_pkg.sv
// rtl/key_debounce16_pkg.sv - key vector types shared with the priority encoder
package key_pkg;
   localparam int NKEYS = 16;
   localparam int CNT_W = 4;

   typedef logic [NKEYS-1:0] key_vec_t;
   typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/key_debounce16_if.sv
// rtl/key_debounce16_if.sv - raw inputs and conditioned key outputs of key_debounce16
interface key_debounce16_if;
   import key_pkg::*;

   key_vec_t in_raw;
   logic     clr;
   key_vec_t keys;
   key_vec_t press;
   logic     press_any;
   key_vec_t held;

   modport master (
      output in_raw, clr,
      input  keys, press, press_any, held
   );

   modport slave (
      input  in_raw, clr,
      output keys, press, press_any, held
   );
endinterface

// File: rtl/key_debounce16_debounce_bit.sv
// rtl/key_debounce16_debounce_bit.sv - one debounce channel: run counter, level and press flops
module debounce_bit
   import key_pkg::*;
#(
   parameter int STABLE_N = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic tick_i,
   input  logic s_i,
   output logic key_o,
   output logic press_o
);
   localparam cnt_t LAST = cnt_t'(STABLE_N - 1);

   cnt_t cnt_q, cnt_d;
   logic key_q, key_d;
   logic press_q, press_d;

   always_comb begin
      cnt_d   = cnt_q;
      key_d   = key_q;
      press_d = 1'b0;
      if (tick_i) begin
         if (s_i == key_q) begin
            cnt_d = '0;
         end else if (cnt_q == LAST) begin
            key_d   = s_i;
            cnt_d   = '0;
            // Only a debounced rising edge pulses; release stays silent.
            press_d = s_i;
         end else begin
            cnt_d = cnt_q + cnt_t'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q   <= '0;
         key_q   <= 1'b0;
         press_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         press_q <= press_d;
      end
   end

   assign key_o   = key_q;
   assign press_o = press_q;
endmodule

// File: rtl/key_debounce16.sv
// rtl/key_debounce16.sv - 16-channel synchroniser, debouncer, press pulse and sticky press register
module key_debounce16
   import key_pkg::*;
#(
   parameter int TICK_DIV = 100000,
   parameter int STABLE_N = 4
) (
   input logic              clk,
   input logic              rstn,
   key_debounce16_if.slave  bus
);
   localparam int             PW    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre_q, pre_d;
   logic          tick;
   key_vec_t      sync1_q, sync2_q;
   key_vec_t      held_q, held_d;
   key_vec_t      keys_w, press_w;

   // Free-running prescaler; nothing but reset touches it.
   always_comb begin
      tick  = (pre_q == PLAST);
      pre_d = tick ? '0 : pre_q + PW'(1);
   end

   always_comb begin
      held_d = (bus.clr ? '0 : held_q) | press_w;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pre_q   <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         held_q  <= '0;
      end else begin
         pre_q   <= pre_d;
         sync1_q <= bus.in_raw;
         sync2_q <= sync1_q;
         held_q  <= held_d;
      end
   end

   for (genvar g = 0; g < NKEYS; g++) begin : g_bit
      debounce_bit #(
         .STABLE_N (STABLE_N)
      ) u_bit (
         .clk     (clk),
         .rstn    (rstn),
         .tick_i  (tick),
         .s_i     (sync2_q[g]),
         .key_o   (keys_w[g]),
         .press_o (press_w[g])
      );
   end

   assign bus.keys      = keys_w;
   assign bus.press     = press_w;
   assign bus.press_any = |press_w;
   assign bus.held      = held_q;
endmodule
